// File: rtl/wb_openram_port0_arbiter.sv
// Two-master Wishbone arbiter for the OpenRAM RW port 0: one access at a time, round-robin on ties.
// Build option: define WB_OPENRAM_ARB_FIXED_PRIO_EN to give port A fixed priority instead.
`timescale 1ns/1ps
module wb_openram_port0_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      wbs_a_cyc_i,
    input  logic                      wbs_a_stb_i,
    input  logic                      wbs_a_we_i,
    input  logic [DATA_WIDTH/8-1:0]   wbs_a_sel_i,
    input  logic [ADDR_WIDTH+1:0]     wbs_a_adr_i,
    input  logic [DATA_WIDTH-1:0]     wbs_a_dat_i,
    output logic                      wbs_a_ack_o,
    output logic [DATA_WIDTH-1:0]     wbs_a_dat_o,

    input  logic                      wbs_b_cyc_i,
    input  logic                      wbs_b_stb_i,
    input  logic                      wbs_b_we_i,
    input  logic [DATA_WIDTH/8-1:0]   wbs_b_sel_i,
    input  logic [ADDR_WIDTH+1:0]     wbs_b_adr_i,
    input  logic [DATA_WIDTH-1:0]     wbs_b_dat_i,
    output logic                      wbs_b_ack_o,
    output logic [DATA_WIDTH-1:0]     wbs_b_dat_o,

    output logic                      ram_clk0,
    output logic                      ram_csb0,
    output logic                      ram_web0,
    output logic [DATA_WIDTH/8-1:0]   ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [DATA_WIDTH-1:0]     ram_din0,
    input  logic [DATA_WIDTH-1:0]     ram_dout0
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_grant_b;
    logic                      r_we;
    logic                      r_ack_a;
    logic                      r_ack_b;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_csb;
    logic                      r_web;
    logic [DATA_WIDTH/8-1:0]   r_wmask;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_din;

    logic                      w_req_a;
    logic                      w_req_b;
    logic                      w_pick_b;
    logic                      w_we;
    logic [DATA_WIDTH/8-1:0]   w_sel;
    logic [ADDR_WIDTH+1:0]     w_adr;
    logic [DATA_WIDTH-1:0]     w_dat;
    logic                      w_cyc_g;
    logic                      w_unused_adr;

    assign w_req_a = wbs_a_cyc_i & wbs_a_stb_i;
    assign w_req_b = wbs_b_cyc_i & wbs_b_stb_i;

`ifdef WB_OPENRAM_ARB_FIXED_PRIO_EN
    assign w_pick_b = w_req_b & ~w_req_a;
`else
    logic r_rr_last_b;
    // On a tie the port that was not served last wins.
    assign w_pick_b = w_req_b & (~w_req_a | ~r_rr_last_b);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_rr_last_b <= 1'b1;
        else if (r_state == ST_ACK)
            r_rr_last_b <= r_grant_b;
    end
`endif

    assign w_we  = w_pick_b ? wbs_b_we_i  : wbs_a_we_i;
    assign w_sel = w_pick_b ? wbs_b_sel_i : wbs_a_sel_i;
    assign w_adr = w_pick_b ? wbs_b_adr_i : wbs_a_adr_i;
    assign w_dat = w_pick_b ? wbs_b_dat_i : wbs_a_dat_i;

    // Dropping cyc mid-access lets the RAM cycle finish but suppresses the ack.
    assign w_cyc_g = r_grant_b ? wbs_b_cyc_i : wbs_a_cyc_i;

    assign w_unused_adr = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_grant_b <= 1'b0;
            r_we      <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_rdata   <= '0;
            r_csb     <= 1'b1;
            r_web     <= 1'b1;
            r_wmask   <= '0;
            r_addr    <= '0;
            r_din     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_a | w_req_b) begin
                        r_grant_b <= w_pick_b;
                        r_we      <= w_we;
                        r_csb     <= 1'b0;
                        r_web     <= ~w_we;
                        r_wmask   <= w_we ? w_sel : '0;
                        r_addr    <= w_adr[ADDR_WIDTH+1:2];
                        r_din     <= w_dat;
                        r_state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_wmask <= '0;
                    if (r_we) begin
                        r_ack_a <= w_cyc_g & ~r_grant_b;
                        r_ack_b <= w_cyc_g & r_grant_b;
                        r_state <= ST_ACK;
                    end else begin
                        r_state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    r_rdata <= ram_dout0;
                    r_ack_a <= w_cyc_g & ~r_grant_b;
                    r_ack_b <= w_cyc_g & r_grant_b;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack_a <= 1'b0;
                    r_ack_b <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_clk0    = wb_clk_i;
    assign ram_csb0    = r_csb;
    assign ram_web0    = r_web;
    assign ram_wmask0  = r_wmask;
    assign ram_addr0   = r_addr;
    assign ram_din0    = r_din;

    assign wbs_a_ack_o = r_ack_a;
    assign wbs_b_ack_o = r_ack_b;
    assign wbs_a_dat_o = r_rdata;
    assign wbs_b_dat_o = r_rdata;

endmodule
